// File: rtl/short_preamble_correlator.sv
// Delay-and-correlate front end: windowed autocorrelation P(n), windowed power R(n)
// and the aligned sample stream, one sample per clock through a 4-stage pipeline.
module short_preamble_correlator #(
  parameter int DELAY      = 16,
  parameter int WINDOW_LEN = 64,
  parameter int OUT_SHIFT  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_corr_tdata,
  output logic        o_corr_tvalid,
  input  logic        o_corr_tready,
  output logic [15:0] o_power_tdata,
  output logic        o_power_tvalid,
  input  logic        o_power_tready,
  output logic [31:0] o_samples_tdata,
  output logic        o_samples_tlast,
  output logic        o_samples_tvalid,
  input  logic        o_samples_tready
);

  localparam int LW  = $clog2(WINDOW_LEN);
  localparam int AW  = 33 + LW;
  localparam int PW  = 32 + LW;
  localparam int DCW = $clog2(DELAY + 1);
  localparam int WCW = $clog2(WINDOW_LEN + 1);
  localparam logic signed [AW-1:0] C_MAX = AW'(32767);
  localparam logic signed [AW-1:0] C_MIN = AW'(-32768);
  localparam logic [PW-1:0]        P_MAX = PW'(32767);

  // Handshake: a beat transfers on any port in a cycle where tvalid & tready are both
  // high at the rising edge. Each output keeps its own taken flag so the stage-4 beat
  // is offered to every consumer exactly once; the whole pipeline (and i_tready)
  // advances only once every consumer has taken or is taking the current beat.
  logic       en;
  logic       in_fire;
  logic [2:0] rdy;
  logic [2:0] out_valid;
  logic [2:0] taken_q, taken_d;

  logic [31:0]    dline_q [DELAY];
  logic [31:0]    dline_d [DELAY];
  logic [DCW-1:0] dfill_q, dfill_d;
  logic [31:0]    dly_word;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_x_q, s1_x_d;
  logic [31:0] s1_d_q, s1_d_d;
  logic        s1_last_q, s1_last_d;

  logic signed [32:0] xi, xq, di, dq;
  logic [31:0]        xi_u, xq_u;
  logic signed [32:0] prod_re, prod_im;
  logic [31:0]        pwr;

  logic               s2_valid_q, s2_valid_d;
  logic [31:0]        s2_x_q, s2_x_d;
  logic               s2_last_q, s2_last_d;
  logic signed [32:0] s2_re_q, s2_re_d;
  logic signed [32:0] s2_im_q, s2_im_d;
  logic [31:0]        s2_pwr_q, s2_pwr_d;

  logic signed [32:0] wre_q [WINDOW_LEN];
  logic signed [32:0] wre_d [WINDOW_LEN];
  logic signed [32:0] wim_q [WINDOW_LEN];
  logic signed [32:0] wim_d [WINDOW_LEN];
  logic [31:0]        wpw_q [WINDOW_LEN];
  logic [31:0]        wpw_d [WINDOW_LEN];
  logic [WCW-1:0]     wfill_q, wfill_d;
  logic signed [32:0] old_re, old_im;
  logic [31:0]        old_pw;

  logic               s3_valid_q, s3_valid_d;
  logic [31:0]        s3_x_q, s3_x_d;
  logic               s3_last_q, s3_last_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d;
  logic signed [AW-1:0] acc_im_q, acc_im_d;
  logic [PW-1:0]        acc_p_q, acc_p_d;

  logic signed [AW-1:0] sh_re, sh_im;
  logic [PW-1:0]        sh_p;
  logic [15:0]          pwr_sat;

  logic        s4_valid_q, s4_valid_d;
  logic [31:0] s4_x_q, s4_x_d;
  logic        s4_last_q, s4_last_d;
  logic [31:0] s4_corr_q, s4_corr_d;
  logic [15:0] s4_pwr_q, s4_pwr_d;

  function automatic logic [15:0] sat_c(input logic signed [AW-1:0] v);
    if (v > C_MAX) return 16'h7fff;
    else if (v < C_MIN) return 16'h8000;
    else return v[15:0];
  endfunction

  assign rdy       = {o_samples_tready, o_power_tready, o_corr_tready};
  assign out_valid = {3{s4_valid_q}} & ~taken_q;
  assign en        = ~s4_valid_q | (&(taken_q | rdy));
  assign in_fire   = i_tvalid & en;
  assign i_tready  = en;

  assign o_corr_tvalid    = out_valid[0];
  assign o_power_tvalid   = out_valid[1];
  assign o_samples_tvalid = out_valid[2];
  assign o_corr_tdata     = s4_corr_q;
  assign o_power_tdata    = s4_pwr_q;
  assign o_samples_tdata  = s4_x_q;
  assign o_samples_tlast  = s4_last_q;

  always_comb begin
    taken_d = taken_q;
    if (en) taken_d = 3'b000;
    else    taken_d = taken_q | (out_valid & rdy);
  end

  // Lag line: reads are masked to zero until DELAY samples have been written.
  always_comb begin
    dline_d  = dline_q;
    dfill_d  = dfill_q;
    dly_word = (dfill_q == DCW'(DELAY)) ? dline_q[DELAY-1] : '0;
    if (in_fire) begin
      for (int i = DELAY - 1; i > 0; i--) dline_d[i] = dline_q[i-1];
      dline_d[0] = i_tdata;
      if (dfill_q != DCW'(DELAY)) dfill_d = dfill_q + DCW'(1);
    end
  end

  always_comb begin
    xi      = 33'($signed(s1_x_q[31:16]));
    xq      = 33'($signed(s1_x_q[15:0]));
    di      = 33'($signed(s1_d_q[31:16]));
    dq      = 33'($signed(s1_d_q[15:0]));
    prod_re = xi * di + xq * dq;
    prod_im = xq * di - xi * dq;
    // Squares fit in 31 bits, so modulo-2^32 arithmetic gives the exact power.
    xi_u    = 32'($signed(s1_x_q[31:16]));
    xq_u    = 32'($signed(s1_x_q[15:0]));
    pwr     = xi_u * xi_u + xq_u * xq_u;
  end

  always_comb begin
    wre_d    = wre_q;
    wim_d    = wim_q;
    wpw_d    = wpw_q;
    wfill_d  = wfill_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    acc_p_d  = acc_p_q;
    old_re   = (wfill_q == WCW'(WINDOW_LEN)) ? wre_q[WINDOW_LEN-1] : '0;
    old_im   = (wfill_q == WCW'(WINDOW_LEN)) ? wim_q[WINDOW_LEN-1] : '0;
    old_pw   = (wfill_q == WCW'(WINDOW_LEN)) ? wpw_q[WINDOW_LEN-1] : '0;
    if (en && s2_valid_q) begin
      for (int i = WINDOW_LEN - 1; i > 0; i--) begin
        wre_d[i] = wre_q[i-1];
        wim_d[i] = wim_q[i-1];
        wpw_d[i] = wpw_q[i-1];
      end
      wre_d[0] = s2_re_q;
      wim_d[0] = s2_im_q;
      wpw_d[0] = s2_pwr_q;
      if (wfill_q != WCW'(WINDOW_LEN)) wfill_d = wfill_q + WCW'(1);
      acc_re_d = acc_re_q + AW'(s2_re_q) - AW'(old_re);
      acc_im_d = acc_im_q + AW'(s2_im_q) - AW'(old_im);
      acc_p_d  = acc_p_q + PW'(s2_pwr_q) - PW'(old_pw);
    end
  end

  always_comb begin
    sh_re   = acc_re_q >>> OUT_SHIFT;
    sh_im   = acc_im_q >>> OUT_SHIFT;
    sh_p    = acc_p_q >> OUT_SHIFT;
    pwr_sat = (sh_p > P_MAX) ? 16'h7fff : sh_p[15:0];
  end

  // The accumulators always describe the beat sitting in S3, so S4 samples them directly.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_d_d     = s1_d_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_last_d  = s2_last_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    s2_pwr_d   = s2_pwr_q;
    s3_valid_d = s3_valid_q;
    s3_x_d     = s3_x_q;
    s3_last_d  = s3_last_q;
    s4_valid_d = s4_valid_q;
    s4_x_d     = s4_x_q;
    s4_last_d  = s4_last_q;
    s4_corr_d  = s4_corr_q;
    s4_pwr_d   = s4_pwr_q;
    if (en) begin
      s1_valid_d = i_tvalid;
      s1_x_d     = i_tdata;
      s1_d_d     = dly_word;
      s1_last_d  = i_tlast;
      s2_valid_d = s1_valid_q;
      s2_x_d     = s1_x_q;
      s2_last_d  = s1_last_q;
      s2_re_d    = prod_re;
      s2_im_d    = prod_im;
      s2_pwr_d   = pwr;
      s3_valid_d = s2_valid_q;
      s3_x_d     = s2_x_q;
      s3_last_d  = s2_last_q;
      s4_valid_d = s3_valid_q;
      s4_x_d     = s3_x_q;
      s4_last_d  = s3_last_q;
      s4_corr_d  = {sat_c(sh_re), sat_c(sh_im)};
      s4_pwr_d   = pwr_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      taken_q    <= '0;
      dfill_q    <= '0;
      wfill_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_d_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_last_q  <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
      s2_pwr_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_x_q     <= '0;
      s3_last_q  <= 1'b0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      acc_p_q    <= '0;
      s4_valid_q <= 1'b0;
      s4_x_q     <= '0;
      s4_last_q  <= 1'b0;
      s4_corr_q  <= '0;
      s4_pwr_q   <= '0;
    end else begin
      taken_q    <= taken_d;
      dfill_q    <= dfill_d;
      wfill_q    <= wfill_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_d_q     <= s1_d_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_last_q  <= s2_last_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
      s2_pwr_q   <= s2_pwr_d;
      s3_valid_q <= s3_valid_d;
      s3_x_q     <= s3_x_d;
      s3_last_q  <= s3_last_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      acc_p_q    <= acc_p_d;
      s4_valid_q <= s4_valid_d;
      s4_x_q     <= s4_x_d;
      s4_last_q  <= s4_last_d;
      s4_corr_q  <= s4_corr_d;
      s4_pwr_q   <= s4_pwr_d;
    end
  end

  // Delay memories carry no reset; the fill counters mask stale contents.
  always_ff @(posedge clk) begin
    dline_q <= dline_d;
    wre_q   <= wre_d;
    wim_q   <= wim_d;
    wpw_q   <= wpw_d;
  end

endmodule

// File: tb/tb_short_preamble_correlator.sv
// Bench for short_preamble_correlator: window-sum reference model, per-stream expected
// queues, directed warm-up/saturation/rotation/backpressure/clear scenarios and random traffic.
module tb_short_preamble_correlator;
  localparam int DELAY = 16;
  localparam int WIN   = 64;
  localparam int SH    = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_corr_tdata;
  logic        o_corr_tvalid;
  logic        o_corr_tready = 1'b1;
  logic [15:0] o_power_tdata;
  logic        o_power_tvalid;
  logic        o_power_tready = 1'b1;
  logic [31:0] o_samples_tdata;
  logic        o_samples_tlast;
  logic        o_samples_tvalid;
  logic        o_samples_tready = 1'b1;

  always #5 clk = ~clk;

  short_preamble_correlator #(.DELAY(DELAY), .WINDOW_LEN(WIN), .OUT_SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_corr_tdata(o_corr_tdata), .o_corr_tvalid(o_corr_tvalid), .o_corr_tready(o_corr_tready),
    .o_power_tdata(o_power_tdata), .o_power_tvalid(o_power_tvalid),
    .o_power_tready(o_power_tready),
    .o_samples_tdata(o_samples_tdata), .o_samples_tlast(o_samples_tlast),
    .o_samples_tvalid(o_samples_tvalid), .o_samples_tready(o_samples_tready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: accepted samples since the last reset/clear and expected output queues.
  int          xi_h[$];
  int          xq_h[$];
  logic [31:0] exp_corr_q[$];
  logic [15:0] exp_pwr_q[$];
  logic [32:0] exp_smp_q[$];
  int          got_ci[$];
  int          got_cq[$];
  int          got_pw[$];
  logic        got_last[$];
  int          first_acc = -1;
  int          first_val = -1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input longint v, input longint lo, input longint hi);
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic int model_corr(input int n, input bit im);
    longint s, ai, aq, bi, bq;
    int lo;
    s  = 0;
    lo = (n - WIN + 1 > 0) ? n - WIN + 1 : 0;
    for (int k = lo; k <= n; k++) begin
      if (k >= DELAY) begin
        ai = xi_h[k];
        aq = xq_h[k];
        bi = xi_h[k-DELAY];
        bq = xq_h[k-DELAY];
        s += im ? (aq * bi - ai * bq) : (ai * bi + aq * bq);
      end
    end
    return sat(s >>> SH, -32768, 32767);
  endfunction

  function automatic int model_pwr(input int n);
    longint s, ai, aq;
    int lo;
    s  = 0;
    lo = (n - WIN + 1 > 0) ? n - WIN + 1 : 0;
    for (int k = lo; k <= n; k++) begin
      ai = xi_h[k];
      aq = xq_h[k];
      s += ai * ai + aq * aq;
    end
    return sat(s >>> SH, 0, 32767);
  endfunction

  logic [2:0]  prev_v = '0;
  logic [2:0]  prev_x = '0;
  logic [31:0] prev_cd, prev_sd;
  logic [15:0] prev_pd;
  logic        prev_sl;

  // Compare process: inputs and readies change only on the falling edge, so #1 later
  // every handshake that the next rising edge will perform is already visible.
  always @(negedge clk) begin
    #1;
    if (reset || clear) begin
      xi_h.delete(); xq_h.delete();
      exp_corr_q.delete(); exp_pwr_q.delete(); exp_smp_q.delete();
      got_ci.delete(); got_cq.delete(); got_pw.delete(); got_last.delete();
      prev_v = '0;
      prev_x = '0;
    end else begin
      if (i_tvalid && i_tready) begin
        int n;
        if (first_acc < 0) first_acc = cyc;
        xi_h.push_back(int'($signed(i_tdata[31:16])));
        xq_h.push_back(int'($signed(i_tdata[15:0])));
        n = xi_h.size() - 1;
        exp_corr_q.push_back({16'(model_corr(n, 1'b0)), 16'(model_corr(n, 1'b1))});
        exp_pwr_q.push_back(16'(model_pwr(n)));
        exp_smp_q.push_back({i_tlast, i_tdata});
      end
      if (o_corr_tvalid && first_val < 0) first_val = cyc;
      if (prev_v[0] && !prev_x[0]) begin
        check("corr_hold_valid", o_corr_tvalid, 1);
        check("corr_hold_data", o_corr_tdata, prev_cd);
      end
      if (prev_v[1] && !prev_x[1]) begin
        check("power_hold_valid", o_power_tvalid, 1);
        check("power_hold_data", o_power_tdata, prev_pd);
      end
      if (prev_v[2] && !prev_x[2]) begin
        check("samples_hold_valid", o_samples_tvalid, 1);
        check("samples_hold_data", {o_samples_tlast, o_samples_tdata}, {prev_sl, prev_sd});
      end
      if (o_corr_tvalid && o_corr_tready) begin
        check("corr_expected_beat", exp_corr_q.size() > 0, 1);
        if (exp_corr_q.size() > 0) check("corr_data", o_corr_tdata, exp_corr_q.pop_front());
        got_ci.push_back(int'($signed(o_corr_tdata[31:16])));
        got_cq.push_back(int'($signed(o_corr_tdata[15:0])));
      end
      if (o_power_tvalid && o_power_tready) begin
        check("power_expected_beat", exp_pwr_q.size() > 0, 1);
        if (exp_pwr_q.size() > 0) check("power_data", o_power_tdata, exp_pwr_q.pop_front());
        got_pw.push_back(int'(o_power_tdata));
      end
      if (o_samples_tvalid && o_samples_tready) begin
        check("samples_expected_beat", exp_smp_q.size() > 0, 1);
        if (exp_smp_q.size() > 0)
          check("samples_data", {o_samples_tlast, o_samples_tdata}, exp_smp_q.pop_front());
        got_last.push_back(o_samples_tlast);
      end
      prev_v  = {o_samples_tvalid, o_power_tvalid, o_corr_tvalid};
      prev_x  = prev_v & {o_samples_tready, o_power_tready, o_corr_tready};
      prev_cd = o_corr_tdata;
      prev_pd = o_power_tdata;
      prev_sd = o_samples_tdata;
      prev_sl = o_samples_tlast;
    end
  end

  int mode = 0;       // 0 idle, 1 (1000,0), 2 full scale, 3 rotating, 4 random
  int vld_pct = 100;
  bit rdy_rand = 1'b0;
  bit pw_hold = 1'b0;

  task automatic drive_cycle();
    int n;
    real ph;
    @(negedge clk);
    n = xi_h.size();
    case (mode)
      1: i_tdata = {16'd1000, 16'd0};
      2: i_tdata = {16'h7fff, 16'h7fff};
      3: begin
        ph      = 3.14159265358979 * n / 32.0;
        i_tdata = {16'(int'(1000.0 * $cos(ph))), 16'(int'(1000.0 * $sin(ph)))};
      end
      default: i_tdata = $urandom;
    endcase
    i_tvalid         = (mode != 0) && ($urandom_range(99) < vld_pct);
    i_tlast          = (mode == 1) && (n == 63 || n == 64);
    o_corr_tready    = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    o_samples_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    o_power_tready   = (rdy_rand ? 1'($urandom_range(1)) : 1'b1) && !pw_hold;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic run_until(input string name, input int target, input int budget);
    int b;
    b = 0;
    while (xi_h.size() < target && b < budget) begin
      drive_cycle();
      b++;
    end
    check(name, xi_h.size() >= target, 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    i_tvalid = 1'b1;
    o_corr_tready = 1'b1; o_power_tready = 1'b1; o_samples_tready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    i_tvalid = 1'b0;
    #2;
    check("clr_corr_valid", o_corr_tvalid, 0);
    check("clr_power_valid", o_power_tvalid, 0);
    check("clr_samples_valid", o_samples_tvalid, 0);
    check("clr_corr_data", o_corr_tdata, 0);
    check("clr_in_ready", i_tready, 1);
  endtask

  initial begin
    int nc, np, ns, nr;
    repeat (3) @(negedge clk);
    #2;
    check("rst_corr_valid", o_corr_tvalid, 0);
    check("rst_power_valid", o_power_tvalid, 0);
    check("rst_samples_valid", o_samples_tvalid, 0);
    check("rst_corr_data", o_corr_tdata, 0);
    check("rst_power_data", o_power_tdata, 0);
    check("rst_samples_data", {o_samples_tlast, o_samples_tdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_in_ready", i_tready, 1);

    // Constant (1000,0): warm-up ramp, tlast on samples 63/64, then clear mid-stream.
    mode = 1;
    run_until("const_progress", 200, 400);
    check("first_latency", first_val - first_acc, 4);
    check("model_pin_c16", model_corr(16, 1'b0), 244);
    check("model_pin_c79", model_corr(79, 1'b0), 15625);
    check("model_pin_p0", model_pwr(0), 244);
    check("const_c15", got_ci[15], 0);
    check("const_c16", got_ci[16], 244);
    check("const_c40", got_ci[40], 6103);
    check("const_c78", got_ci[78], 15380);
    check("const_c79", got_ci[79], 15625);
    check("const_c150", got_ci[150], 15625);
    check("const_q100", got_cq[100], 0);
    check("const_p0", got_pw[0], 244);
    check("const_p31", got_pw[31], 7812);
    check("const_p63", got_pw[63], 15625);
    check("const_p120", got_pw[120], 15625);
    check("tlast_62", got_last[62], 0);
    check("tlast_63", got_last[63], 1);
    check("tlast_64", got_last[64], 1);
    check("tlast_65", got_last[65], 0);
    do_clear();
    run_until("postclr_progress", 120, 300);
    check("postclr_c15", got_ci[15], 0);
    check("postclr_c16", got_ci[16], 244);
    check("postclr_c40", got_ci[40], 6103);
    check("postclr_c79", got_ci[79], 15625);
    check("postclr_p0", got_pw[0], 244);
    check("postclr_p63", got_pw[63], 15625);

    // Full-scale constant: both outputs saturate, Q stays zero.
    do_clear();
    mode = 2;
    run_until("full_progress", 150, 300);
    check("full_ci", got_ci[140], 32767);
    check("full_cq", got_cq[140], 0);
    check("full_p", got_pw[140], 32767);

    // Rotating phasor: correlation rotates to the quadrature axis.
    do_clear();
    mode = 3;
    run_until("rot_progress", 150, 300);
    check("rot_ci_near0", (got_ci[140] >= -3 && got_ci[140] <= 3), 1);
    check("rot_cq_near", (got_cq[140] >= 15622 && got_cq[140] <= 15628), 1);
    check("rot_p_near", (got_pw[140] >= 15622 && got_pw[140] <= 15628), 1);

    // Power consumer stalls for 10 cycles while the others stay ready.
    do_clear();
    mode = 4;
    run_cycles(40);
    pw_hold = 1'b1;
    nc = 0; np = 0; ns = 0; nr = 0;
    repeat (10) begin
      drive_cycle();
      #2;
      if (o_corr_tvalid && o_corr_tready) nc++;
      if (o_power_tvalid && o_power_tready) np++;
      if (o_samples_tvalid && o_samples_tready) ns++;
      if (i_tready) nr++;
    end
    pw_hold = 1'b0;
    check("stall_corr_beats", nc, 1);
    check("stall_samples_beats", ns, 1);
    check("stall_power_beats", np, 0);
    check("stall_in_ready_le1", nr <= 1, 1);
    run_cycles(40);

    // Random data, random input gaps and independent 50% readies.
    vld_pct = 70;
    rdy_rand = 1'b1;
    run_until("random_progress", xi_h.size() + 1000, 10000);

    mode = 0;
    rdy_rand = 1'b0;
    run_cycles(30);
    check("drain_corr", exp_corr_q.size(), 0);
    check("drain_power", exp_pwr_q.size(), 0);
    check("drain_samples", exp_smp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/short_preamble_correlator.md
Name: short_preamble_correlator

Overview:
- Delay-and-correlate front end for short-preamble detection.
- Consumes the sc16 sample stream and produces three lockstep streams for the downstream short preamble detector:
  - windowed autocorrelation P(n) = sum x[k]·conj(x[k−DELAY])
  - windowed power R(n) = sum |x[k]|²
  - the samples themselves, aligned to P and R.
- Fully pipelined, one sample per clock. Per-output handshakes are independent, so one stalled consumer cannot drop or duplicate beats on the others.

Parameters:
- DELAY, 16: correlation lag in samples (short training symbol length), ≥1.
- WINDOW_LEN, 64: moving-sum length, power of 2, ≥2.
- OUT_SHIFT, 12: arithmetic right shift applied to accumulators before 16-bit saturation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset on state, ports unaffected
- i_tdata  in  32  sample, I [31:16], Q [15:0], signed
- i_tlast  in  1  passed through with sample
- i_tvalid  in  1
- i_tready  out  1
- o_corr_tdata  out  32  P(n), I [31:16], Q [15:0], signed saturated
- o_corr_tvalid  out  1
- o_corr_tready  in  1
- o_power_tdata  out  16  R(n), saturated to 0..32767
- o_power_tvalid  out  1
- o_power_tready  in  1
- o_samples_tdata  out  32  x[n] aligned with P(n), R(n)
- o_samples_tlast  out  1
- o_samples_tvalid  out  1
- o_samples_tready  in  1

Behaviour:
- Reset/clear:
  - all pipeline valids, accepted flags, fill counters and accumulators go to 0.
  - All o_*_tvalid = 0, o_* data = 0.
  - i_tready = 1 the cycle after reset/clear deasserts.
- Pipeline: 4 stages, advanced by a global enable en.
  - S1 registers x[n] and d = x[n−DELAY] from the sample delay line.
  - S2 computes:
    - prod_re = xi·di + xq·dq (33b signed)
    - prod_im = xq·di − xi·dq (33b signed)
    - pwr = xi² + xq² (32b unsigned)
  - S3 updates the accumulators:
    - acc_c += prod − prod[n−WINDOW_LEN], per I/Q, width 33+log2(WINDOW_LEN)
    - acc_p += pwr − pwr[n−WINDOW_LEN], width 32+log2(WINDOW_LEN)
  - S4 computes the outputs:
    - o_corr: acc_c >>> OUT_SHIFT (floor), saturated to [−32768, 32767].
    - o_power: acc_p >> OUT_SHIFT, saturated to [0, 32767].
  - Latency from input accept to output valid is 4 cycles with no stall.
- Warm-up:
  - Fill counters (saturating) mask delay-line and window-line reads to 0 until DELAY resp. WINDOW_LEN samples have entered.
  - Delay memories need no reset (SRL/RAM allowed).
  - All samples are output; none are discarded during warm-up.
- Output handshake:
  - Per-output accepted flag a[k].
  - o_k_tvalid = s4_valid & ~a[k].
  - a[k] sets when o_k_tvalid & o_k_tready.
  - en = ~s4_valid | for-all-k (a[k] | o_k_tready).
  - a[*] clears when en.
  - o_*_tvalid never deasserts without a transfer; o_* data stable while tvalid is high.
- Input: i_tready = en.
  - The input beat enters S1 on i_tvalid & en.
  - Bubbles propagate as invalid stages; accumulators and fill counters update only on valid beats.
- tlast: carried with the sample only, no effect on arithmetic; the window continues across tlast.
- Simultaneous reset/clear with any handshake: reset/clear wins and the beat is dropped.

Test Plan:
- Constant x=(1000,0), all readies high, defaults:
  - Output n (0-based) has corr_I = floor((n−15)·1e6/4096) for 16≤n≤79, and 0 for n<16.
  - power = floor((n+1)·1e6/4096) for n<64.
  - From n≥79: corr=(15625,0), power=15625.
  - First output valid 4 cycles after first accept.
- Full-scale x=(32767,32767) constant: steady-state corr=(32767,0), power=32767 (saturation). Q never nonzero.
- Rotating input x[n]=1000·e^(jπn/32), rounded: steady-state corr ≈ (0, 15625) ±3 LSB; power ≈ 15625 ±3.
- Backpressure:
  - o_power_tready low for 10 cycles with the others high: corr and samples each accept exactly one beat then hold tvalid low.
  - i_tready falls within 1 cycle.
  - After release, all three streams carry identical, gap-free sequences vs. the no-stall golden model.
  - Randomized per-output ready (50%) over 1000 samples matches the golden model.
- Clear at sample 200 of the constant-input stream:
  - No outputs for pre-clear in-flight beats.
  - Post-clear outputs repeat the warm-up sequence of the first scenario exactly.
- tlast on input samples 63 and 64 appears on o_samples_tlast of the same beats; corr/power unaffected.
